// File: rtl/gpio_cfg_pkg.sv
// Shared constants, FSM state type, pin bundle and pad-index mapping for the GPIO serial configuration loader.
package gpio_cfg_pkg;

   localparam int CFG_W = 13;
   localparam int NPADS = 38;
   localparam int NHALF = NPADS / 2;
   localparam int IDX_W = 5;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      LOAD_HI  = 3'd3,
      LOAD_LO  = 3'd4
   } state_e;

   typedef struct packed {
      logic clk;
      logic load;
      logic resetn;
      logic data_1;
      logic data_2;
   } pins_t;

   // Word index -> pad number; index 0 is always the pad farthest along its chain.
   function automatic int chain1_pad(input int idx);
      return NHALF - 1 - idx;
   endfunction

   function automatic int chain2_pad(input int idx);
      return NHALF + idx;
   endfunction

endpackage

// File: rtl/gpio_serial_phase_ctr.sv
// Phase timer: phase_end pulses on the HALF-th cycle of every phase while run is high.
// One-cycle decode from the count register; restarts from zero after each phase_end or when run drops.
module gpio_serial_phase_ctr #(
   parameter int HALF = 1
) (
   input  logic wb_clk_i,
   input  logic wb_rstn_i,
   input  logic run,
   output logic phase_end
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign phase_end = run && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!run || phase_end) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts both pad chains MSB-first (farthest pad first), then strobes load; all chain pins are registered.
// xfer_start at edge N gives SHIFT_LO pins from N+1; requests while busy or in bit-bang mode are dropped.
module gpio_serial_loader
   import gpio_cfg_pkg::*;
#(
   parameter int HALF = 1
) (
   input  logic             wb_clk_i,
   input  logic             wb_rstn_i,
   input  logic             xfer_start,
   output logic [IDX_W-1:0] cfg_idx,
   input  logic [CFG_W-1:0] cfg_word_1,
   input  logic [CFG_W-1:0] cfg_word_2,
   input  logic             bb_enable,
   input  logic             bb_clock,
   input  logic             bb_load,
   input  logic             bb_resetn,
   input  logic             bb_data_1,
   input  logic             bb_data_2,
   output logic             serial_clock,
   output logic             serial_load,
   output logic             serial_resetn,
   output logic             serial_data_1,
   output logic             serial_data_2,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = $clog2(CFG_W);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CFG_W - 1);
   localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NHALF - 1);

   state_e           state_q, state_d;
   logic [CFG_W-1:0] shift1_q, shift1_d;
   logic [CFG_W-1:0] shift2_q, shift2_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [IDX_W-1:0] word_q, word_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   pins_t            pins_q, pins_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             phase_end;

   gpio_serial_phase_ctr #(
      .HALF(HALF)
   ) u_phase (
      .wb_clk_i  (wb_clk_i),
      .wb_rstn_i (wb_rstn_i),
      .run       (state_q != IDLE),
      .phase_end (phase_end)
   );

   always_comb begin
      state_d  = state_q;
      shift1_d = shift1_q;
      shift2_d = shift2_q;
      bit_d    = bit_q;
      word_d   = word_q;
      idx_d    = idx_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (xfer_start && !bb_enable) begin
               shift1_d = cfg_word_1;
               shift2_d = cfg_word_2;
               bit_d    = '0;
               word_d   = '0;
               state_d  = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (phase_end) begin
               state_d = SHIFT_HI;
               // The register file is addressed one half-bit ahead so the reload below sees the next word.
               if (bit_q == LAST_BIT && word_q < LAST_WORD) begin
                  idx_d = word_q + IDX_W'(1);
               end
            end
         end
         SHIFT_HI: begin
            if (phase_end) begin
               if (bit_q < LAST_BIT) begin
                  shift1_d = {shift1_q[CFG_W-2:0], 1'b0};
                  shift2_d = {shift2_q[CFG_W-2:0], 1'b0};
                  bit_d    = bit_q + BIT_W'(1);
                  state_d  = SHIFT_LO;
               end else if (word_q < LAST_WORD) begin
                  shift1_d = cfg_word_1;
                  shift2_d = cfg_word_2;
                  bit_d    = '0;
                  word_d   = word_q + IDX_W'(1);
                  state_d  = SHIFT_LO;
               end else begin
                  state_d = LOAD_HI;
               end
            end
         end
         LOAD_HI: begin
            if (phase_end) begin
               state_d = LOAD_LO;
            end
         end
         LOAD_LO: begin
            if (phase_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
               word_d  = '0;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Pins are computed from the next state so they change on the same edge as the FSM.
      pins_d        = '0;
      pins_d.resetn = 1'b1;
      unique case (state_d)
         IDLE: begin
            if (bb_enable) begin
               pins_d.clk    = bb_clock;
               pins_d.load   = bb_load;
               pins_d.resetn = bb_resetn;
               pins_d.data_1 = bb_data_1;
               pins_d.data_2 = bb_data_2;
            end
         end
         SHIFT_LO: begin
            pins_d.data_1 = shift1_d[CFG_W-1];
            pins_d.data_2 = shift2_d[CFG_W-1];
         end
         SHIFT_HI: begin
            pins_d.clk    = 1'b1;
            pins_d.data_1 = shift1_d[CFG_W-1];
            pins_d.data_2 = shift2_d[CFG_W-1];
         end
         LOAD_HI: begin
            pins_d.load = 1'b1;
         end
         default: begin
            pins_d.load = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         state_q  <= IDLE;
         shift1_q <= '0;
         shift2_q <= '0;
         bit_q    <= '0;
         word_q   <= '0;
         idx_q    <= '0;
         pins_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift1_q <= shift1_d;
         shift2_q <= shift2_d;
         bit_q    <= bit_d;
         word_q   <= word_d;
         idx_q    <= idx_d;
         pins_q   <= pins_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign cfg_idx       = idx_q;
   assign serial_clock  = pins_q.clk;
   assign serial_load   = pins_q.load;
   assign serial_resetn = pins_q.resetn;
   assign serial_data_1 = pins_q.data_1;
   assign serial_data_2 = pins_q.data_2;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: doc/gpio_serial_loader.md
# gpio_serial_loader

Housekeeping-side engine that pushes the 38 per-pad 13-bit GPIO configuration words into the two serial configuration chains (user-1 side pads 0–18, user-2 side pads 37–19) and then pulses the load strobe. It sits between the housekeeping GPIO configuration register file and the `gpio_control_block` chains. The bit-bang control register drives the same chain pins directly when bit-bang mode is enabled.

## Interface
- `CFG_W`, 13: bits per pad configuration word.
- `NHALF`, 19: pads per chain.
- `HALF`, 1: system clock cycles per `serial_clock` phase (≥1).

- `wb_clk_i` in 1: system clock.
- `wb_rstn_i` in 1: reset, synchronous, active-low.
- `xfer_start` in 1: single-cycle request to start a full transfer.
- `cfg_idx` out 5: word index 0..NHALF-1 currently requested from the register file.
- `cfg_word_1` in CFG_W: config of pad `18-cfg_idx`, combinational from the register file.
- `cfg_word_2` in CFG_W: config of pad `19+cfg_idx`, combinational from the register file.
- `bb_enable`, `bb_clock`, `bb_load`, `bb_resetn`, `bb_data_1`, `bb_data_2` in 1 each: bit-bang register fields.
- `serial_clock`, `serial_load`, `serial_resetn`, `serial_data_1`, `serial_data_2` out 1 each: chain pins.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LOAD_HI, LOAD_LO.
- IDLE:
  - If `bb_enable`=1, the chain pins follow the `bb_*` inputs, registered with 1 cycle latency.
  - Otherwise the outputs are `serial_clock`=0, `serial_load`=0, `serial_resetn`=1, and data=0.
- Start condition: `xfer_start`=1 in IDLE with `bb_enable`=0.
  - Capture `cfg_word_1` and `cfg_word_2` at `cfg_idx`=0 into two CFG_W shift registers.
  - Clear the bit counter (0..CFG_W-1) and the word counter. Go to SHIFT_LO.
- `xfer_start` is ignored while `busy`=1 or while `bb_enable`=1. Requests are not queued.
- SHIFT_LO:
  - `serial_clock`=0. `serial_data_*` = MSB of each shift register.
  - After HALF cycles, go to SHIFT_HI.
- SHIFT_HI:
  - `serial_clock`=1 and the data outputs stay stable. After HALF cycles:
    - If the bit counter < CFG_W-1: shift both registers left by one, increment the bit counter, go to SHIFT_LO.
    - Else, if the word counter < NHALF-1: increment the word counter (`cfg_idx` follows), reload both registers from the new words, clear the bit counter, go to SHIFT_LO.
    - Else: go to LOAD_HI.
- Bit order: MSB first. Farthest pad first: pad 18 then down to 0 on chain 1; pad 19 then up to 37 on chain 2.
- LOAD_HI: `serial_load`=1, `serial_clock`=0, data=0, for HALF cycles.
- LOAD_LO: `serial_load`=0 for HALF cycles. Then `done`=1 for 1 cycle and return to IDLE.
- `bb_enable` changes during a transfer have no effect until IDLE.

## Timing
- Reset values: `serial_clock`=0, `serial_load`=0, `serial_resetn`=0, `serial_data_*`=0, `busy`=0, `done`=0, `cfg_idx`=0.
- `serial_resetn` rises to 1 on the first cycle after reset release.
- `xfer_start` sampled at edge N: `busy`=1 and SHIFT_LO outputs valid from edge N+1.
- First `serial_clock` rise at N+1+HALF.
- Data is stable for ≥HALF cycles before and after each rising edge.
- Total busy time is (2·CFG_W·NHALF + 2)·HALF cycles. With defaults that is 496.
- `done` is asserted in the first IDLE cycle. `busy` is low in that cycle.
- A new `xfer_start` may be sampled in the same cycle `done`=1.
- `wb_rstn_i`=0 mid-transfer: all outputs return to reset values on the next edge. No load pulse is issued.

## Structure
- Package `gpio_cfg_pkg` holds:
  - `CFG_W`=13, `NHALF`=19, `NPADS`=38;
  - the state enum;
  - the pad-index mapping functions `chain1_pad(idx)=18-idx` and `chain2_pad(idx)=19+idx`.
- Sub-module `gpio_serial_phase_ctr` is the HALF-cycle phase timer, producing `phase_end`. The shifters and FSM stay in the top module.

## Test plan
- Defaults, all words 0x1809, start pulse:
  - 247 rising edges on `serial_clock`, then one `serial_load` pulse, then `done`.
  - The bench's 19-deep chain model holds 0x1809 in every position on both chains.
  - Busy time is 496 cycles.
- Distinct words per pad (pad p = p·0x10F mod 0x2000):
  - The chain models reproduce the per-pad mapping, i.e. pad 0 is nearest on chain 1 and pad 37 is nearest on chain 2.
- `bb_enable`=1 with `bb_clock` toggled 13 times and `bb_data_2`=1:
  - The pins track the inputs 1 cycle later.
  - A concurrent `xfer_start` is ignored (`busy` stays 0).
- Second `xfer_start` at word 5 of a transfer: ignored, and exactly 247 clocks are issued.
- Reset asserted after 100 `serial_clock` edges:
  - Next cycle: all outputs at reset values, no `serial_load` pulse.
  - A subsequent transfer completes normally.
- HALF=3:
  - Every `serial_clock` phase and the load pulse are 3 cycles.
  - Busy time is 1488 cycles.
